// File: rtl/seq_restoring_divider_if.sv
// Handshake and result bundle for seq_restoring_divider: the requester drives start/operands,
// the divider returns busy/done and the held results.
interface seq_restoring_divider_if #(
  parameter int unsigned WIDTH = 8
);
  logic             start;
  logic [WIDTH-1:0] dividend;
  logic [WIDTH-1:0] divisor;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] quotient;
  logic [WIDTH-1:0] remainder;
  logic             div_by_zero;

  modport master (
    output start, dividend, divisor,
    input  busy, done, quotient, remainder, div_by_zero
  );

  modport slave (
    input  start, dividend, divisor,
    output busy, done, quotient, remainder, div_by_zero
  );
endinterface

// File: rtl/seq_restoring_divider.sv
// Sequential restoring divider, one quotient bit per clock, WIDTH cycles per division.
// Define DIVIDER_SIGNED_EN for two's-complement operands (truncating division).
module seq_restoring_divider #(
  parameter int unsigned WIDTH = 8
) (
  input  logic                   clk,
  input  logic                   rst_n,
  seq_restoring_divider_if.slave bus
);

  localparam int unsigned CntW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

  state_e            state_q, state_d;
  logic [WIDTH:0]    rem_q;
  logic [WIDTH-1:0]  dvd_q;
  logic [WIDTH-1:0]  dvs_q;
  logic [CntW-1:0]   cnt_q;
  logic              dvz_q;
  logic [WIDTH-1:0]  quotient_q;
  logic [WIDTH-1:0]  remainder_q;
  logic              dbz_q;

  logic              accept;
  logic              finish;
  logic [WIDTH+1:0]  shifted;
  logic [WIDTH+1:0]  diff;
  logic              ge;
  logic [WIDTH:0]    rem_nxt;
  logic [WIDTH-1:0]  dvd_nxt;
  logic [WIDTH-1:0]  dvd_mag;
  logic [WIDTH-1:0]  dvs_mag;
  logic [WIDTH-1:0]  q_fix;
  logic [WIDTH-1:0]  r_fix;
  logic [WIDTH-1:0]  dvz_rem;

  assign accept = bus.start && (state_q != StRun);
  assign finish = dvz_q || (cnt_q == CntW'(1));

  // One extra guard bit so the sign of the trial difference decides the quotient bit.
  assign shifted = {rem_q, dvd_q[WIDTH-1]};
  assign diff    = shifted - {2'b00, dvs_q};
  assign ge      = ~diff[WIDTH+1];
  assign rem_nxt = ge ? diff[WIDTH:0] : shifted[WIDTH:0];
  assign dvd_nxt = {dvd_q[WIDTH-2:0], ge};

`ifdef DIVIDER_SIGNED_EN
  logic dvd_neg_q;
  logic dvs_neg_q;

  assign dvd_mag = bus.dividend[WIDTH-1] ? -bus.dividend : bus.dividend;
  assign dvs_mag = bus.divisor[WIDTH-1]  ? -bus.divisor  : bus.divisor;
  assign q_fix   = (dvd_neg_q ^ dvs_neg_q) ? -dvd_nxt : dvd_nxt;
  assign r_fix   = dvd_neg_q ? -rem_nxt[WIDTH-1:0] : rem_nxt[WIDTH-1:0];
  // Re-applying the sign to the magnitude recovers the original dividend.
  assign dvz_rem = dvd_neg_q ? -dvd_q : dvd_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dvd_neg_q <= 1'b0;
      dvs_neg_q <= 1'b0;
    end else if (accept) begin
      dvd_neg_q <= bus.dividend[WIDTH-1];
      dvs_neg_q <= bus.divisor[WIDTH-1];
    end
  end
`else
  assign dvd_mag = bus.dividend;
  assign dvs_mag = bus.divisor;
  assign q_fix   = dvd_nxt;
  assign r_fix   = rem_nxt[WIDTH-1:0];
  assign dvz_rem = dvd_q;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle, StDone: state_d = accept ? StRun : StIdle;
      StRun:          state_d = finish ? StDone : StRun;
      default:        state_d = StIdle;
    endcase
  end

  always_comb begin
    bus.busy = (state_q == StRun);
    bus.done = (state_q == StDone);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rem_q       <= '0;
      dvd_q       <= '0;
      dvs_q       <= '0;
      cnt_q       <= '0;
      dvz_q       <= 1'b0;
      quotient_q  <= '0;
      remainder_q <= '0;
      dbz_q       <= 1'b0;
    end else if (accept) begin
      rem_q <= '0;
      dvd_q <= dvd_mag;
      dvs_q <= dvs_mag;
      cnt_q <= CntW'(WIDTH);
      dvz_q <= (bus.divisor == '0);
    end else if (state_q == StRun) begin
      if (dvz_q) begin
        quotient_q  <= '1;
        remainder_q <= dvz_rem;
        dbz_q       <= 1'b1;
      end else begin
        rem_q <= rem_nxt;
        dvd_q <= dvd_nxt;
        cnt_q <= cnt_q - CntW'(1);
        if (finish) begin
          quotient_q  <= q_fix;
          remainder_q <= r_fix;
          dbz_q       <= 1'b0;
        end
      end
    end
  end

  assign bus.quotient    = quotient_q;
  assign bus.remainder   = remainder_q;
  assign bus.div_by_zero = dbz_q;

endmodule

// File: tb/tb_seq_restoring_divider.sv
// Scoreboard bench for seq_restoring_divider: stimulus pushes expected results, a monitor
// pops and compares on every done strobe, including the cycle it arrives in.
module tb_seq_restoring_divider;
  localparam int unsigned WIDTH = 8;

  typedef struct {
    logic [7:0] q;
    logic [7:0] r;
    logic       z;
    int         cyc;
  } exp_t;

  logic clk;
  logic rst_n;
  int   cyc;
  int   checks;
  int   errors;
  exp_t sb[$];

  seq_restoring_divider_if #(.WIDTH(WIDTH)) bus ();

  seq_restoring_divider #(.WIDTH(WIDTH)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Monitor: every done strobe must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (rst_n && bus.done) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_done: got done=1 expected done=0 (t=%0t)", $time);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check("quotient", {24'd0, bus.quotient}, {24'd0, e.q});
        check("remainder", {24'd0, bus.remainder}, {24'd0, e.r});
        check("div_by_zero", {31'd0, bus.div_by_zero}, {31'd0, e.z});
        check("done_cycle", cyc, e.cyc);
        check("busy_at_done", {31'd0, bus.busy}, 32'd0);
      end
    end
  end

  task automatic issue(input logic [7:0] a, input logic [7:0] b, input logic [7:0] q,
                       input logic [7:0] r, input logic z, input int lat);
    @(negedge clk);
    bus.start    = 1'b1;
    bus.dividend = a;
    bus.divisor  = b;
    sb.push_back('{q: q, r: r, z: z, cyc: cyc + 1 + lat});
    @(negedge clk);
    bus.start = 1'b0;
  endtask

  task automatic wait_idle();
    for (int i = 0; i < 40 && sb.size() != 0; i++) @(negedge clk);
    if (sb.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL done_timeout: got %0d pending expected 0", sb.size());
      sb.delete();
    end
    @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    checks       = 0;
    errors       = 0;
    rst_n        = 1'b0;
    bus.start    = 1'b0;
    bus.dividend = '0;
    bus.divisor  = '0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    check("rst_busy", {31'd0, bus.busy}, 32'd0);
    check("rst_done", {31'd0, bus.done}, 32'd0);
    check("rst_quotient", {24'd0, bus.quotient}, 32'd0);
    check("rst_remainder", {24'd0, bus.remainder}, 32'd0);
    check("rst_dbz", {31'd0, bus.div_by_zero}, 32'd0);

    // 100/7 with busy tracked across the eight running cycles.
    issue(8'd100, 8'd7, 8'd14, 8'd2, 1'b0, 8);
    for (int i = 0; i < 8; i++) begin
      check("busy_running", {31'd0, bus.busy}, 32'd1);
      @(negedge clk);
    end
    check("busy_after_done", {31'd0, bus.busy}, 32'd0);
    wait_idle();

    issue(8'd3, 8'd2, 8'd1, 8'd1, 1'b0, 8);      wait_idle();
    issue(8'd255, 8'd1, 8'd255, 8'd0, 1'b0, 8);  wait_idle();
    issue(8'd0, 8'd100, 8'd0, 8'd0, 1'b0, 8);    wait_idle();
    issue(8'd15, 8'd15, 8'd1, 8'd0, 1'b0, 8);    wait_idle();
    repeat (5) @(negedge clk);
    check("held_quotient", {24'd0, bus.quotient}, 32'd1);
    check("held_remainder", {24'd0, bus.remainder}, 32'd0);
    issue(8'd5, 8'd200, 8'd0, 8'd5, 1'b0, 8);    wait_idle();

    // Divide by zero, then a normal division clears the flag.
    issue(8'd200, 8'd0, 8'd255, 8'd200, 1'b1, 1);
    check("dbz_busy", {31'd0, bus.busy}, 32'd1);
    wait_idle();
    issue(8'd30, 8'd6, 8'd5, 8'd0, 1'b0, 8);     wait_idle();

    // start while busy is ignored.
    issue(8'd100, 8'd7, 8'd14, 8'd2, 1'b0, 8);
    @(negedge clk);
    bus.start    = 1'b1;
    bus.dividend = 8'd9;
    bus.divisor  = 8'd3;
    @(negedge clk);
    bus.start = 1'b0;
    // Back-to-back: new request in the done cycle.
    for (int i = 0; i < 20 && !bus.done; i++) @(negedge clk);
    check("done_seen_for_b2b", {31'd0, bus.done}, 32'd1);
    bus.start    = 1'b1;
    bus.dividend = 8'd9;
    bus.divisor  = 8'd3;
    sb.push_back('{q: 8'd3, r: 8'd0, z: 1'b0, cyc: cyc + 1 + 8});
    @(negedge clk);
    bus.start = 1'b0;
    wait_idle();

    // Asynchronous reset mid-division discards it.
    issue(8'd255, 8'd16, 8'd15, 8'd15, 1'b0, 8);
    repeat (2) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    sb.delete();
    check("arst_busy", {31'd0, bus.busy}, 32'd0);
    check("arst_done", {31'd0, bus.done}, 32'd0);
    check("arst_quotient", {24'd0, bus.quotient}, 32'd0);
    check("arst_remainder", {24'd0, bus.remainder}, 32'd0);
    check("arst_dbz", {31'd0, bus.div_by_zero}, 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (12) @(negedge clk);
`ifdef DIVIDER_SIGNED_EN
    issue(8'd255, 8'd16, 8'd0, 8'hFF, 1'b0, 8);  wait_idle();
    issue(8'h9C, 8'd7, 8'hF2, 8'hFE, 1'b0, 8);   wait_idle();
    issue(8'd100, 8'hF9, 8'hF2, 8'd2, 1'b0, 8);  wait_idle();
    issue(8'h80, 8'hFF, 8'h80, 8'd0, 1'b0, 8);   wait_idle();
    issue(8'h9C, 8'd0, 8'hFF, 8'h9C, 1'b1, 1);   wait_idle();
`else
    issue(8'd255, 8'd16, 8'd15, 8'd15, 1'b0, 8); wait_idle();
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
